// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the serial receiver: FSM state encoding, the smallest
// usable baud divisor and the number of data bits per frame.
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Divisors below this value are raised to it; with fewer than two clocks
  // per bit there is no mid-bit sample point.
  localparam int DIV_MIN = 2;

  // Data bits per 8N1 frame.
  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/baud_cnt.sv
// -----------------------------------------------------------------------------
// baud_cnt
// Down-counter that times the sample points of the serial receiver.
// A load takes priority over counting. The counter expires while it holds 1,
// then falls to 0 and rests there, so it never wraps.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset (counter -> 0)
//   load      load load_val on the next edge
//   load_val  value to load (clocks until expiry)
//   expire    high while the counter holds 1
// -----------------------------------------------------------------------------
module baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign expire = (cnt == DIV_W'(1));

endmodule

// File: rtl/serial_rcvr.sv
// -----------------------------------------------------------------------------
// serial_rcvr
// 8N1 serial receiver, LSB first, with a CPU-side receive data register and
// status flags.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sin          asynchronous serial line, idle high
//   div          clocks per bit (values below 2 behave as 2)
//   rd_ack       one-cycle pulse: the CPU has read rx_data
//   rx_data      last received byte
//   rx_ready     an unread byte is present
//   overrun      a byte completed while rx_ready was already set
//   framing_err  the stop bit of the last frame was sampled low
//   int_rx       rx_ready | overrun | framing_err
//   fsm_state    current receiver state, for observation only
//
// CPU handshake: rx_ready acts as "valid" for rx_data. The CPU acknowledges a
// read with a single-cycle rd_ack, which clears rx_ready, overrun and
// framing_err on the next edge. When rd_ack coincides with a frame
// completion, the new byte is loaded, rx_ready stays set and overrun stays
// clear, because the CPU has just consumed the previous byte.
// -----------------------------------------------------------------------------
module serial_rcvr
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic [DIV_W-1:0] div,
  input  logic             rd_ack,
  output logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             overrun,
  output logic             framing_err,
  output logic             int_rx,
  output rx_state_t        fsm_state
);

  logic             sin_meta;
  logic             sin_s;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [DIV_W-1:0] eff_now;
  logic [DIV_W-1:0] eff_q;
  logic [DIV_W-1:0] cnt_val;
  logic             cnt_load;
  logic             expire;
  logic             start_frame;
  logic             data_begin;
  logic             bit_take;
  logic             stop_take;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             done_q;
  logic             stop_q;
  logic             armed;

  // Two-flop synchronizer; both stages reset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_meta <= 1'b1;
      sin_s    <= 1'b1;
    end else begin
      sin_meta <= sin;
      sin_s    <= sin_meta;
    end
  end

  assign eff_now = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_load    = 1'b0;
    cnt_val     = eff_q;
    start_frame = 1'b0;
    data_begin  = 1'b0;
    bit_take    = 1'b0;
    stop_take   = 1'b0;
    case (state)
      IDLE: begin
        // armed is low after a frame whose stop bit was low, so a held-low
        // line (break) yields one frame and no more until it goes high.
        if (armed && !sin_s) begin
          state_nxt   = START;
          cnt_load    = 1'b1;
          cnt_val     = eff_now >> 1;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (expire) begin
          if (!sin_s) begin
            state_nxt  = DATA;
            cnt_load   = 1'b1;
            data_begin = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          bit_take = 1'b1;
          cnt_load = 1'b1;
          if (bit_idx == 3'(FRAME_BITS - 1)) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (expire) begin
          stop_take = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  baud_cnt #(
    .DIV_W(DIV_W)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (expire)
  );

  // Frame datapath. The divisor is captured at the start of a frame so a
  // later change of div cannot disturb it. The stop sample is registered and
  // the completion applied one edge later (done_q).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eff_q   <= DIV_W'(DIV_MIN);
      bit_idx <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b1;
      armed   <= 1'b1;
    end else begin
      if (start_frame) begin
        eff_q <= eff_now;
      end
      if (data_begin) begin
        bit_idx <= '0;
      end else if (bit_take) begin
        shift_q[bit_idx] <= sin_s;
        bit_idx          <= bit_idx + 3'd1;
      end
      done_q <= stop_take;
      if (stop_take) begin
        stop_q <= sin_s;
      end
      if (stop_take && !sin_s) begin
        armed <= 1'b0;
      end else if (state == IDLE && sin_s) begin
        armed <= 1'b1;
      end
    end
  end

  // CPU-visible register and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= 8'h00;
      rx_ready    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else if (done_q) begin
      if (!rx_ready || rd_ack) begin
        rx_data  <= shift_q;
        rx_ready <= 1'b1;
        overrun  <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
      framing_err <= ~stop_q;
    end else if (rd_ack) begin
      rx_ready    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end
  end

  assign int_rx    = rx_ready | overrun | framing_err;
  assign fsm_state = state;

endmodule

// File: doc/serial_rcvr.md
SERIAL_RCVR -- requirements
Module: serial_rcvr

Interface
REQ-001 Parameter DIV_W, default 16, width of the baud divisor.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 sin  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 div  input  DIV_W  clocks per bit; the value is formed from the divisor LSB/MSB registers.
REQ-006 rd_ack  input  1  single-cycle pulse, issued when the CPU reads the RX data register.
REQ-007 rx_data  output  8  last received byte, registered.
REQ-008 rx_ready  output  1  unread byte is present.
REQ-009 overrun  output  1  a byte completed while rx_ready was 1.
REQ-010 framing_err  output  1  the stop bit of the last frame was sampled low.
REQ-011 int_rx  output  1  interrupt request, equal to rx_ready OR overrun OR framing_err.

Function
REQ-012 sin SHALL pass through a 2-flop synchronizer before any use; all later references to sin mean the synchronized value.
REQ-013 The effective divisor SHALL be max(div, 2), sampled on entry to START and held constant for the rest of the frame.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE: on synchronized sin = 0, go to START and load the baud counter with eff_div>>1.
REQ-016 START: when the counter expires, sample sin; if 0, go to DATA, load eff_div, set bit index 0; if 1 (false start), return to IDLE with no flag change.
REQ-017 DATA: on each counter expiry, shift sin into bit[index], reload eff_div, increment index; after index 7, go to STOP.
REQ-018 STOP: on counter expiry, sample sin, perform the completion actions in REQ-019 to REQ-021, and return to IDLE.
REQ-019 Completion with rx_ready = 0: load rx_data, set rx_ready, set framing_err to the inverse of the stop sample.
REQ-020 Completion with rx_ready = 1 and no rd_ack in the same cycle: keep rx_data unchanged, set overrun, update framing_err.
REQ-021 Completion in the same cycle as rd_ack: completion wins; load rx_data, rx_ready stays 1, overrun is not set.
REQ-022 rd_ack without a completion in the same cycle SHALL clear rx_ready, overrun and framing_err on the next edge.
REQ-023 Latency: rx_ready SHALL rise 3 + (eff_div>>1) + 9*eff_div clock edges after the first edge at which the synchronizer input stage captures sin = 0.
REQ-024 The baud counter SHALL count down, be DIV_W bits wide, expire at 1, and never wrap.
REQ-025 A change of div mid-frame SHALL NOT affect the frame in progress.
REQ-026 sin low for the whole of IDLE (line break) SHALL produce one frame with framing_err = 1, then re-arm only after sin returns high.

Reset
REQ-027 On rst = 0 the block SHALL asynchronously enter IDLE with rx_data = 8'h00, rx_ready = 0, overrun = 0, framing_err = 0, counter = 0, index = 0, and both synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; no flag rises after release until a new full frame completes.

Structure
REQ-029 A shared package uart_pkg SHALL hold the state encoding (IDLE, START, DATA, STOP), the DIV_MIN = 2 constant, and the frame length constant 8.
REQ-030 The baud counter with load and expire logic SHALL be one sub-module, baud_cnt; the FSM, shift register and flags stay in serial_rcvr.
REQ-031 Target size is 120-400 lines of RTL; there are no latches and no combinational loop through int_rx.

Verification
REQ-032 div = 6, send byte 0xCE as 8N1 -> rx_data = 0xCE, rx_ready = 1 exactly 60 edges after start capture, framing_err = 0, int_rx = 1.
REQ-033 Two frames 0x5A then 0x3C with no rd_ack -> rx_data = 0x5A, overrun = 1; then rd_ack -> rx_ready, overrun and int_rx all 0.
REQ-034 div = 6, low glitch on sin of 2 clocks -> FSM returns to IDLE; rx_ready stays 0 and no flag is set.
REQ-035 Frame 0xA5 with stop bit driven 0 -> rx_data = 0xA5, framing_err = 1, int_rx = 1.
REQ-036 rd_ack pulsed on the same edge a second frame 0x11 completes -> rx_data = 0x11, rx_ready = 1, overrun = 0.
REQ-037 div = 0 -> the block behaves exactly as div = 2; byte 0xFF received correctly. Separately, rst asserted during DATA -> all outputs return to their reset values immediately.
